// File: rtl/spike_rate_if.sv
// Rate-sample output channel of spike_rate_decoder (valid/ready with sample payload).
// With SPIKE_ISI_EN defined the channel also carries isi_min alongside rate_out.
interface spike_rate_if #(
    parameter int CNT_W = 8
`ifdef SPIKE_ISI_EN
    , parameter int WIN_W = 8
`endif
);
    logic [CNT_W-1:0] rate_out;
    logic             rate_valid;
    logic             rate_ready;
    logic             saturated;
`ifdef SPIKE_ISI_EN
    logic [WIN_W-1:0] isi_min;

    modport master (output rate_out, output rate_valid, output saturated,
                    output isi_min, input rate_ready);
    modport slave  (input rate_out, input rate_valid, input saturated,
                    input isi_min, output rate_ready);
`else
    modport master (output rate_out, output rate_valid, output saturated,
                    input rate_ready);
    modport slave  (input rate_out, input rate_valid, input saturated,
                    output rate_ready);
`endif
endinterface

// File: rtl/spike_rate_decoder.sv
// Counts spikes over back-to-back windows of window_len cycles and offers one rate sample per
// window on a one-deep valid/ready buffer. Optional macro SPIKE_ISI_EN adds min inter-spike interval.
module spike_rate_decoder #(
    parameter int WIN_W = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIN_W-1:0] window_len,
    input  logic             spike_in,
    spike_rate_if.master     rate_if,
    output logic             dropped,
    output logic             busy
);
    typedef enum logic {IDLE, COUNT} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic [WIN_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_nxt;
    logic             sat_q, sat_d, sat_nxt;
    logic [CNT_W-1:0] rate_out_q, rate_out_d;
    logic             rate_valid_q, rate_valid_d;
    logic             saturated_q, saturated_d;
    logic             dropped_q, dropped_d;
    logic             start_ok, win_end, buf_free;
`ifdef SPIKE_ISI_EN
    logic [WIN_W-1:0] since_q, since_d;
    logic [WIN_W-1:0] isi_q, isi_d, isi_nxt;
    logic [WIN_W-1:0] isi_out_q, isi_out_d;
    logic             seen_q, seen_d;
`endif

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + 1'b1;
    endfunction

    always_comb begin
        start_ok = enable && (window_len != '0);
        win_end  = (state_q == COUNT) && (rem_q == WIN_W'(1));
        // A sample being consumed this cycle frees the buffer for the one completing now
        buf_free = !rate_valid_q || rate_if.rate_ready;
        cnt_nxt  = spike_in ? sat_inc(cnt_q) : cnt_q;
        sat_nxt  = sat_q || (spike_in && (cnt_q == CNT_MAX));

        state_d      = state_q;
        rem_d        = rem_q;
        cnt_d        = cnt_q;
        sat_d        = sat_q;
        rate_out_d   = rate_out_q;
        rate_valid_d = rate_valid_q && !rate_if.rate_ready;
        saturated_d  = saturated_q;
        dropped_d    = 1'b0;
`ifdef SPIKE_ISI_EN
        isi_nxt = isi_q;
        if (spike_in && seen_q && ((isi_q == '0) || (since_q < isi_q)))
            isi_nxt = since_q;
        since_d   = since_q;
        isi_d     = isi_q;
        seen_d    = seen_q;
        isi_out_d = isi_out_q;
`endif

        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d = COUNT;
                    rem_d   = window_len;
                    cnt_d   = '0;
                    sat_d   = 1'b0;
`ifdef SPIKE_ISI_EN
                    since_d = '0;
                    isi_d   = '0;
                    seen_d  = 1'b0;
`endif
                end
            end
            default: begin
                rem_d = rem_q - 1'b1;
                cnt_d = cnt_nxt;
                sat_d = sat_nxt;
`ifdef SPIKE_ISI_EN
                since_d = spike_in ? WIN_W'(1)
                                   : ((since_q == '1) ? since_q : since_q + 1'b1);
                seen_d  = seen_q || spike_in;
                isi_d   = isi_nxt;
`endif
                if (win_end) begin
                    if (buf_free) begin
                        rate_out_d   = cnt_nxt;
                        saturated_d  = sat_nxt;
                        rate_valid_d = 1'b1;
`ifdef SPIKE_ISI_EN
                        isi_out_d    = isi_nxt;
`endif
                    end else begin
                        dropped_d = 1'b1;
                    end
                    if (start_ok) begin
                        rem_d = window_len;
                        cnt_d = '0;
                        sat_d = 1'b0;
`ifdef SPIKE_ISI_EN
                        since_d = '0;
                        isi_d   = '0;
                        seen_d  = 1'b0;
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            rem_q        <= '0;
            cnt_q        <= '0;
            sat_q        <= 1'b0;
            rate_out_q   <= '0;
            rate_valid_q <= 1'b0;
            saturated_q  <= 1'b0;
            dropped_q    <= 1'b0;
`ifdef SPIKE_ISI_EN
            since_q   <= '0;
            isi_q     <= '0;
            seen_q    <= 1'b0;
            isi_out_q <= '0;
`endif
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            cnt_q        <= cnt_d;
            sat_q        <= sat_d;
            rate_out_q   <= rate_out_d;
            rate_valid_q <= rate_valid_d;
            saturated_q  <= saturated_d;
            dropped_q    <= dropped_d;
`ifdef SPIKE_ISI_EN
            since_q   <= since_d;
            isi_q     <= isi_d;
            seen_q    <= seen_d;
            isi_out_q <= isi_out_d;
`endif
        end
    end

    assign rate_if.rate_out   = rate_out_q;
    assign rate_if.rate_valid = rate_valid_q;
    assign rate_if.saturated  = saturated_q;
`ifdef SPIKE_ISI_EN
    assign rate_if.isi_min    = isi_out_q;
`endif
    assign dropped = dropped_q;
    assign busy    = (state_q == COUNT);
endmodule

// File: tb/tb_spike_rate_decoder.sv
// Scoreboard bench for spike_rate_decoder: expected samples are queued as windows are driven
// and compared whenever the output channel transfers a sample.
module tb_spike_rate_decoder;
    localparam int WIN_W = 8;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    typedef struct {
        int cnt;
        int sat;
        int isi;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic [WIN_W-1:0] window_len;
    logic             spike_in;
    logic             dropped;
    logic             busy;

    int   n_checks = 0;
    int   n_bad    = 0;
    int   drop_cnt = 0;
    int   gcyc     = 0;
    exp_t exp_q[$];
    exp_t e_mon;
    logic             prev_hold = 1'b0;
    logic [CNT_W-1:0] prev_out;
    logic             prev_sat;

`ifdef SPIKE_ISI_EN
    spike_rate_if #(.CNT_W(CNT_W), .WIN_W(WIN_W)) rif ();
`else
    spike_rate_if #(.CNT_W(CNT_W)) rif ();
`endif

    spike_rate_decoder #(.WIN_W(WIN_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .window_len (window_len),
        .spike_in   (spike_in),
        .rate_if    (rif),
        .dropped    (dropped),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) gcyc <= gcyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Output monitor: hold stability, scoreboard pop on transfer, drop pulse counting
    always @(negedge clk) begin
        if (reset) begin
            if (prev_hold) begin
                check_eq("hold_valid", rif.rate_valid, 1);
                check_eq("hold_rate", rif.rate_out, prev_out);
                check_eq("hold_sat", rif.saturated, prev_sat);
            end
            if (rif.rate_valid && rif.rate_ready) begin
                check_eq("sample_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e_mon = exp_q.pop_front();
                    check_eq("rate_out", rif.rate_out, e_mon.cnt);
                    check_eq("saturated", rif.saturated, e_mon.sat);
`ifdef SPIKE_ISI_EN
                    check_eq("isi_min", rif.isi_min, e_mon.isi);
`endif
                end
            end
            if (dropped) drop_cnt++;
            prev_hold = rif.rate_valid && !rif.rate_ready;
            prev_out  = rif.rate_out;
            prev_sat  = rif.saturated;
        end else begin
            prev_hold = 1'b0;
        end
    end

    function automatic logic pat(input int mode, input int k);
        case (mode)
            0:       return (gcyc % 4) == 0;
            1:       return 1'b1;
            2:       return (k == 2) || (k == 5) || (k == 6);
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // rmode: 0 ready always 1, 1 ready always 0, 2 ready only on the final window's last cycle
    task automatic run_windows(input int len, input int nwin, input int mode,
                               input int rmode, input int npush);
        exp_t e;
        int   cnt, last, isi, d;
        logic s;
        @(posedge clk); #1;
        enable         = 1'b1;
        window_len     = WIN_W'(len);
        spike_in       = 1'b1;
        rif.rate_ready = (rmode == 0);
        for (int w = 0; w < nwin; w++) begin
            cnt = 0; last = -1; isi = 0;
            for (int k = 0; k < len; k++) begin
                @(posedge clk); #1;
                if (w == 0 && k == 0) check_eq("busy_count", busy, 1);
                s        = pat(mode, k);
                spike_in = s;
                enable   = !((w == nwin - 1) && (k == len - 1));
                rif.rate_ready = (rmode == 0) ||
                                 ((rmode == 2) && (w == nwin - 1) && (k == len - 1));
                if (s) begin
                    cnt++;
                    if (last >= 0) begin
                        d = k - last;
                        if (isi == 0 || d < isi) isi = d;
                    end
                    last = k;
                end
            end
            if (w < npush) begin
                e.cnt = (cnt > CMAX) ? CMAX : cnt;
                e.sat = (cnt > CMAX) ? 1 : 0;
                e.isi = isi;
                exp_q.push_back(e);
            end
        end
    endtask

    initial begin
        int d0;
        reset = 1'b0; enable = 1'b0; window_len = 8'd10; spike_in = 1'b0;
        rif.rate_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_rate", rif.rate_out, 0);
        check_eq("rst_valid", rif.rate_valid, 0);
        check_eq("rst_sat", rif.saturated, 0);
        check_eq("rst_dropped", dropped, 0);
        check_eq("rst_busy", busy, 0);
        reset = 1'b1;

        // disabled: no windows, no samples
        repeat (50) begin @(posedge clk); #1; spike_in = ~spike_in; end
        check_eq("idle_valid", rif.rate_valid, 0);
        check_eq("idle_busy", busy, 0);

        // zero window length never starts
        enable = 1'b1; window_len = '0;
        repeat (10) @(posedge clk);
        #1;
        check_eq("len0_busy", busy, 0);
        check_eq("len0_valid", rif.rate_valid, 0);
        enable = 1'b0;

        run_windows(10, 5, 0, 0, 5);
        run_windows(20, 1, 1, 0, 1);
        run_windows(15, 1, 1, 0, 1);
        run_windows(16, 1, 1, 0, 1);
        run_windows(1, 6, 3, 0, 6);
        repeat (3) @(posedge clk);

        // buffer held across three windows: two drops
        d0 = drop_cnt;
        run_windows(5, 3, 3, 1, 1);
        repeat (2) @(posedge clk);
        #1;
        check_eq("drop_count", drop_cnt - d0, 2);
        check_eq("held_valid", rif.rate_valid, 1);
        rif.rate_ready = 1'b1;
        repeat (3) @(posedge clk);
        run_windows(5, 1, 3, 0, 1);
        repeat (3) @(posedge clk);

        // window end coincides with transfer of the previous sample
        d0 = drop_cnt;
        run_windows(6, 2, 3, 2, 2);
        @(posedge clk); #1;
        check_eq("same_cyc_valid", rif.rate_valid, 1);
        check_eq("same_cyc_drop", drop_cnt - d0, 0);
        rif.rate_ready = 1'b1;
        repeat (3) @(posedge clk);

        // asynchronous reset mid-window with a sample held
        run_windows(10, 1, 1, 1, 0);
        @(posedge clk); #1;
        enable = 1'b1; window_len = 8'd10; spike_in = 1'b1;
        repeat (3) begin @(posedge clk); #1; spike_in = 1'b1; end
        #1 reset = 1'b0; enable = 1'b0;
        #1;
        check_eq("arst_rate", rif.rate_out, 0);
        check_eq("arst_valid", rif.rate_valid, 0);
        check_eq("arst_sat", rif.saturated, 0);
        check_eq("arst_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1; rif.rate_ready = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check_eq("post_rst_valid", rif.rate_valid, 0);
        run_windows(10, 1, 2, 0, 1);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        #1;
        check_eq("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/spike_rate_decoder.md
Name: spike_rate_decoder

Overview:
- Downstream consumer of the LIF neuron's spike output.
- Counts spikes over a programmable window of clock cycles and emits one rate sample per window on a valid/ready output interface.
- Feeds the readout/classification stage, and lets benches check neuron firing rates against the stimulus.

Parameters:
- WIN_W, 8, width of the window-length input and internal cycle counter
- CNT_W, 8, width of the spike count / rate output

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- enable  input  1  run control; 1 = start or continue windows, 0 = stop after the current window
- window_len  input  WIN_W  window length in cycles; sampled only at window start
- spike_in  input  1  spike from the neuron; each cycle at 1 counts as one spike
- rate_out  output  CNT_W  spike count of the last completed window
- rate_valid  output  1  rate_out holds an unconsumed sample
- rate_ready  input  1  consumer accepts the sample when rate_valid && rate_ready
- saturated  output  1  the sample in rate_out hit the count limit 2^CNT_W-1
- dropped  output  1  one-cycle pulse: a completed sample was discarded because the buffer was full
- busy  output  1  1 while in COUNT

Behaviour:
- Reset values (reset=0, asynchronous): state=IDLE; rate_out=0, rate_valid=0, saturated=0, dropped=0, busy=0; internal counters=0.
- State machine has two states: IDLE and COUNT.
- IDLE -> COUNT: on a cycle with enable=1 and window_len!=0.
  - The window length is latched into the remaining-cycle counter (rem).
  - The spike count is cleared.
  - spike_in in this transition cycle is not counted.
- IDLE with window_len=0: no transition. Stay in IDLE and produce no sample.
- COUNT, every cycle:
  - If spike_in=1, the count increments, saturating at 2^CNT_W-1.
  - An internal saturation flag is set once the increment is blocked.
  - rem decrements.
- Window end is the COUNT cycle with rem==1. That cycle's spike_in is included in the sample.
  - The final count (including that cycle) is the completed sample.
  - If the buffer is free (rate_valid=0), or is being consumed this same cycle (rate_valid && rate_ready): load rate_out and saturated, and set rate_valid=1 on the next edge.
  - Otherwise, discard the sample and pulse dropped=1 for exactly one cycle (the cycle after window end). The buffer is unchanged.
  - If enable=1: restart immediately, with no gap cycle. Re-latch window_len, clear the count, and count spike_in from the next cycle.
  - If enable=0: go to IDLE.
  - If enable=1 but window_len=0 at restart: go to IDLE.
- enable=0 mid-window does not abort the window. The current window completes, then the block goes to IDLE.
- Latency: the sample for a window of N cycles starting after edge t is valid from edge t+N onward.
- Handshake rules:
  - rate_out, saturated and rate_valid are stable while rate_valid=1 and rate_ready=0.
  - rate_valid clears on the edge after a transfer, unless a new sample loads on that same edge.
  - rate_ready is ignored when rate_valid=0.
- A window of length 1 counts only its single cycle; back-to-back windows of length 1 produce a sample every cycle.
- Reset mid-window: abandon everything immediately, with all values as listed under Reset values. No partial sample is emitted.

Optional Feature:
- Macro SPIKE_ISI_EN.
- When defined:
  - Adds output isi_min (WIN_W), registered and handshaked together with rate_out.
  - isi_min is the minimum cycle distance between consecutive counted spikes inside the window.
  - isi_min is 0 if the window contained fewer than 2 spikes.
  - Spikes in adjacent cycles give isi_min=1.
  - The interval tracker resets at each window start and never spans windows.
  - isi_min resets to 0.
- When undefined: the isi_min port and all its logic are absent. All other behaviour is identical.

Test Plan:
- Reset with enable=0, window_len=10 -> all outputs 0; rate_valid stays 0 for 50 cycles; busy=0.
- enable=1, window_len=10, spike_in=1 every 4th cycle, rate_ready=1 -> rate_out sequence matches the counts per window (2 or 3 depending on phase); rate_valid pulses once every 10 cycles; no gap cycles between windows.
- CNT_W=4, window_len=20, spike_in=1 constantly -> rate_out=15, saturated=1.
- rate_ready=0 held across three windows of length 5 -> the first sample is held stable; dropped pulses exactly twice. Then set rate_ready=1 -> the first sample is transferred; the next window's sample loads normally.
- Window ends in the same cycle as a transfer (rate_ready=1 when rem==1) -> new sample loads; rate_valid stays 1; dropped=0.
- Drive reset=0 at cycle 3 of a 10-cycle window with spikes present -> outputs are 0 immediately (asynchronously); no sample appears after release until a full new window completes. With SPIKE_ISI_EN defined: spikes at offsets 2, 5, 6 -> isi_min=1, rate_out=3.
